// File: rtl/bcd_down_counter.sv
// bcd_down_counter: cascaded multi-digit BCD down-counter with synchronous load.
// Outputs packed BCD digits, a one-cycle borrow pulse on underflow (0..0 -> 9..9)
// and a registered zero flag.
// Optional macro BCD_DOWN_SATURATE_EN: when defined, the counter holds at zero
// instead of wrapping, and borrow is never asserted.
module bcd_down_counter #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  borrow,
  output logic                  zero
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d;
  logic         borrow_q, borrow_d;
  logic         zero_q, zero_d;
  logic [W-1:0] load_san;
  logic [W-1:0] count_dec;
  logic         is_zero;

  // Clamp any non-BCD preset digit (A..F) to 9 so the digit invariant holds.
  always_comb begin
    load_san = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_san[4*i +: 4] = 4'd9;
      else                            load_san[4*i +: 4] = load_val[4*i +: 4];
    end
  end

  // Single-cycle ripple-borrow decrement; an all-zero count naturally yields 9..9.
  always_comb begin
    logic chain;
    count_dec = count_q;
    chain     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (chain) begin
        if (count_q[4*i +: 4] == 4'd0) count_dec[4*i +: 4] = 4'd9;
        else                           count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
      end
      chain = chain & (count_q[4*i +: 4] == 4'd0);
    end
  end

  assign is_zero = (count_q == '0);

  // Next-state selection: load > enable > hold (reset applied in the register).
  always_comb begin
    count_d  = count_q;
    borrow_d = 1'b0;
    zero_d   = zero_q;
    if (load) begin
      count_d = load_san;
      zero_d  = (load_san == '0);
    end else if (enable) begin
`ifdef BCD_DOWN_SATURATE_EN
      if (!is_zero) begin
        count_d = count_dec;
        zero_d  = (count_dec == '0);
      end
`else
      count_d  = count_dec;
      borrow_d = is_zero;
      zero_d   = (count_dec == '0);
`endif
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      count_q  <= count_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign count  = count_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Testbench for bcd_down_counter: directed scenarios plus a random soak, checked
// against a decimal-integer reference model. Two instances (4 and 2 digits)
// share the control inputs.
module tb_bcd_down_counter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] load_val4;
  logic [15:0] count4;
  logic        borrow4, zero4;
  logic [7:0]  load_val2;
  logic [7:0]  count2;
  logic        borrow2, zero2;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // Reference model state: plain decimal values.
  int unsigned m_val4 = 0, m_val2 = 0;
  logic        m_bor4 = 0, m_bor2 = 0;

  bcd_down_counter #(.DIGITS(4)) u_dut4 (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_val(load_val4), .count(count4), .borrow(borrow4), .zero(zero4)
  );

  bcd_down_counter #(.DIGITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_val(load_val2), .count(count2), .borrow(borrow2), .zero(zero2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned pow10(input int unsigned d);
    int unsigned p = 1;
    for (int i = 0; i < int'(d); i++) p = p * 10;
    return p;
  endfunction

  // Decimal value of a preset, with digits above 9 read as 9.
  function automatic int unsigned sanit(input logic [31:0] lv, input int unsigned d);
    int unsigned v = 0;
    logic [31:0] t = lv;
    for (int i = 0; i < int'(d); i++) begin
      int unsigned dig = int'(t[4*i +: 4]);
      if (dig > 9) dig = 9;
      v = v + dig * pow10(i);
    end
    return v;
  endfunction

  // Packed BCD encoding of a decimal value.
  function automatic logic [31:0] enc(input int unsigned v, input int unsigned d);
    logic [31:0] r = '0;
    int unsigned x = v;
    for (int i = 0; i < int'(d); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void model_step(inout int unsigned v, inout logic b,
                                     input logic [31:0] lv, input int unsigned d);
    b = 1'b0;
    if (reset)       v = 0;
    else if (load)   v = sanit(lv, d);
    else if (enable) begin
      if (v == 0) begin
`ifndef BCD_DOWN_SATURATE_EN
        v = pow10(d) - 1;
        b = 1'b1;
`endif
      end else begin
        v = v - 1;
      end
    end
  endfunction

  // Apply inputs for one clock, advance the model, compare both instances.
  task automatic apply(input logic rst, input logic en, input logic ld, input logic [15:0] lv4);
    reset     = rst;
    enable    = en;
    load      = ld;
    load_val4 = lv4;
    load_val2 = 8'($urandom);
    @(posedge clk);
    #1;
    model_step(m_val4, m_bor4, 32'(load_val4), 4);
    model_step(m_val2, m_bor2, 32'(load_val2), 2);
    check("count4", 32'(count4), enc(m_val4, 4));
    check("borrow4", 32'(borrow4), 32'(m_bor4));
    check("zero4", 32'(zero4), 32'(m_val4 == 0));
    check("count2", 32'(count2), enc(m_val2, 2));
    check("borrow2", 32'(borrow2), 32'(m_bor2));
    check("zero2", 32'(zero2), 32'(m_val2 == 0));
  endtask

  initial begin
    logic [7:0] c2;
    reset = 1'b1; enable = 1'b1; load = 1'b1; load_val4 = 16'h1234; load_val2 = 8'h56;

    // Reset dominates load and enable.
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 1'b1, 1'b1, 16'($urandom));
      check("rst_count", 32'(count4), 32'h0000);
      check("rst_borrow", 32'(borrow4), 32'h0);
      check("rst_zero", 32'(zero4), 32'h1);
    end

    // Load and decrement across digit boundaries.
    apply(1'b0, 1'b0, 1'b1, 16'h0102);
    check("ld_0102", 32'(count4), 32'h0102);
    apply(1'b0, 1'b1, 1'b0, 16'h0);
    check("dec_0101", 32'(count4), 32'h0101);
    apply(1'b0, 1'b1, 1'b0, 16'h0);
    check("dec_0100", 32'(count4), 32'h0100);
    apply(1'b0, 1'b1, 1'b0, 16'h0);
    check("dec_0099", 32'(count4), 32'h0099);
    check("dec_zero", 32'(zero4), 32'h0);

    // Underflow.
    apply(1'b0, 1'b0, 1'b1, 16'h0001);
    apply(1'b0, 1'b1, 1'b0, 16'h0);
    check("uf_0000", 32'(count4), 32'h0000);
    check("uf_zero", 32'(zero4), 32'h1);
    apply(1'b0, 1'b1, 1'b0, 16'h0);
`ifdef BCD_DOWN_SATURATE_EN
    check("uf_sat", 32'(count4), 32'h0000);
    check("uf_sat_b", 32'(borrow4), 32'h0);
    check("uf_sat_z", 32'(zero4), 32'h1);
`else
    check("uf_9999", 32'(count4), 32'h9999);
    check("uf_borrow", 32'(borrow4), 32'h1);
    check("uf_zero9", 32'(zero4), 32'h0);
`endif
    apply(1'b0, 1'b1, 1'b0, 16'h0);
`ifdef BCD_DOWN_SATURATE_EN
    check("uf_sat2", 32'(count4), 32'h0000);
`else
    check("uf_9998", 32'(count4), 32'h9998);
`endif
    check("uf_borrow2", 32'(borrow4), 32'h0);

    // Sanitise and load-over-enable priority.
    apply(1'b0, 1'b1, 1'b1, 16'hA3F5);
    check("san_9395", 32'(count4), 32'h9395);

    // Hold, then reset while enabled.
    apply(1'b0, 1'b0, 1'b1, 16'h1000);
    apply(1'b0, 1'b1, 1'b0, 16'h0);
    check("h_0999", 32'(count4), 32'h0999);
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b0, 1'b0, 16'($urandom));
      check("hold_cnt", 32'(count4), 32'h0999);
      check("hold_bor", 32'(borrow4), 32'h0);
    end
    apply(1'b1, 1'b1, 1'b0, 16'h0);
    check("mrst_cnt", 32'(count4), 32'h0000);
    check("mrst_zero", 32'(zero4), 32'h1);

    // Random soak; loads favour small values so wrap-around is exercised.
    for (int k = 0; k < 10000; k++) begin
      logic r, e, l;
      logic [15:0] lv;
      r  = ($urandom_range(0, 199) == 0);
      l  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      apply(r, e, l, lv);
      c2 = count2;
      check("dig2_lo", 32'(c2[3:0] <= 4'd9), 32'h1);
      check("dig2_hi", 32'(c2[7:4] <= 4'd9), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Multi-digit cascaded BCD down-counter with synchronous load. It is the count-down counterpart to the team's BCD up-counter.
- Used for preset countdown timers feeding the seven-segment display path.
- Produces packed BCD digits, a one-cycle borrow pulse on underflow, and a registered zero flag.

Parameters:
- DIGITS, 4, number of cascaded BCD digits (1..8); digit 0 is least significant.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  decrement request; sampled on the rising edge.
- load  input  1  synchronous load strobe; higher priority than enable.
- load_val  input  4*DIGITS  packed BCD preset; digit i is bits [4i+3:4i].
- count  output  4*DIGITS  packed BCD current value; register output.
- borrow  output  1  one-cycle underflow pulse; register output.
- zero  output  1  high when count is all zeros; register output.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high; no asynchronous paths.
- Reset values: count = 0, borrow = 0, zero = 1.
- Priority on each rising edge: reset > load > enable > hold.
- Load:
  - count <= load_val, with per-digit sanitising: any digit > 9 is stored as 9.
  - borrow <= 0; zero <= 1 only if the sanitised value is all zeros.
  - Latency: 1 cycle; new value is visible on count the cycle after load is sampled high.
- Enable with count != 0:
  - Digit 0 decrements by 1.
  - Any digit that is 0 while all lower digits are 0 becomes 9; the first non-zero digit above it decrements by 1; higher digits are unchanged.
  - borrow <= 0; zero <= 1 only if the new count is all zeros (e.g. 0001 -> 0000).
- Enable with count == 0 (underflow):
  - All digits <= 9, so count shows 99..9.
  - borrow <= 1 for exactly that one cycle, concurrent with the 99..9 value; zero <= 0.
- Hold (enable = 0, load = 0): count unchanged; borrow <= 0; zero unchanged.
- Borrow is never high for two consecutive cycles. The only exception is back-to-back underflows, which are impossible because 99..9 != 0.
- Digit invariant: every count digit is always 0..9. No invalid BCD code is reachable from reset, load, or decrement.
- Simultaneous load and enable: load wins; no decrement that cycle.
- Reset mid-count or during a borrow cycle: next cycle count = 0, borrow = 0, zero = 1.
- Carry chain is combinational across digits within a single cycle (single-cycle decrement for all DIGITS values); no inter-digit pipelining.

Optional Feature:
- Macro: BCD_DOWN_SATURATE_EN.
- Defined: counter saturates. Enable at count == 0 holds count at 0, borrow stays 0, and zero stays 1. Borrow is permanently 0 in this build.
- Undefined (default): wrap-around behaviour as described above, with the borrow pulse.

Test Plan:
- Reset check: assert reset for 2 cycles with enable = 1 and load = 1 -> count = 0000, borrow = 0, zero = 1 in both cycles.
- Load and decrement: load 0102, then enable for 3 cycles -> count = 0101, 0100, 0099; borrow = 0; zero = 0 throughout.
- Underflow: load 0001, enable 2 cycles -> count 0000 (zero = 1), then 9999 with borrow = 1 for exactly one cycle. Next enabled cycle -> 9998, borrow = 0. With BCD_DOWN_SATURATE_EN, the second cycle stays 0000, borrow = 0.
- Sanitise and priority: load = 1 and enable = 1 together, load_val = 0xA3F5 -> count = 9395 next cycle (no decrement applied).
- Hold and mid-operation reset: load 1000, enable 1 cycle -> 0999; deassert enable for 5 cycles -> stays 0999 with borrow = 0. Then reset during enable -> 0000, zero = 1.
- Random soak: DIGITS = 2, random enable/load/load_val for 10k cycles against a decimal reference model -> count matches model, every digit ≤ 9, borrow only on 00 -> 99 transitions.
